// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters, the arbiter and the single memory port.
// The arbiter uses the slave view; the surrounding core/memory uses the master view.
interface mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_ack_o;
  logic        instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_wen_i;
  logic [1:0]  data_len_i;
  logic [31:0] data_wdata_i;
  logic        data_ack_o;
  logic        data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_wen_i,
           data_len_i, data_wdata_i, mem_rdata_i, mem_rvalid_i,
    output instr_ack_o, instr_err_o, instr_rdata_o, data_ack_o, data_err_o,
           data_rdata_o, mem_req_o, mem_addr_o, mem_wen_o, mem_wmask_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_wen_i,
           data_len_i, data_wdata_i, mem_rdata_i, mem_rvalid_i,
    input  instr_ack_o, instr_err_o, instr_rdata_o, data_ack_o, data_err_o,
           data_rdata_o, mem_req_o, mem_addr_o, mem_wen_o, mem_wmask_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for one memory port: data priority with a starvation
// guard, a single outstanding transaction, store lane formatting and timeouts.
module mem_arbiter #(
  parameter int TIMEOUT         = 255,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  localparam logic [7:0] TIMER_LAST   = 8'(TIMEOUT - 1);
  localparam logic [3:0] STREAK_LIMIT = 4'(DATA_STREAK_MAX);

  function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
    case (len)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] len, input logic [1:0] off);
    case (len)
      2'd0:    store_mask = 4'b0001 << off;
      2'd1:    store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic [7:0]  timer_r;
  logic [2:0]  streak_r;
  logic        mem_req_r;
  logic [31:0] mem_addr_r;
  logic        mem_wen_r;
  logic [3:0]  mem_wmask_r;
  logic [31:0] mem_wdata_r;

  logic        grant_data_s;
  logic        grant_instr_s;
  logic        data_bad_s;
  logic        timeout_s;
  logic        unused_s;

  assign unused_s = ^bus.instr_addr_i[1:0];

  // Arbitration, alignment check and timeout detection
  always_comb begin
    grant_data_s  = 1'b0;
    grant_instr_s = 1'b0;
    data_bad_s    = misaligned(bus.data_len_i, bus.data_addr_i[1:0]);
    timeout_s     = (state_r != IDLE) && !bus.mem_rvalid_i && (timer_r == TIMER_LAST);
    if ((state_r == IDLE) && !reset_i) begin
      if (bus.data_req_i && (({1'b0, streak_r} < STREAK_LIMIT) || !bus.instr_req_i)) begin
        grant_data_s = 1'b1;
      end else if (bus.instr_req_i) begin
        grant_instr_s = 1'b1;
      end else begin
        grant_data_s  = 1'b0;
        grant_instr_s = 1'b0;
      end
    end else begin
      grant_data_s  = 1'b0;
      grant_instr_s = 1'b0;
    end
  end

  // Responses are combinational so the requester sees them in the response cycle
  assign bus.instr_ack_o   = !reset_i && (state_r == IBUSY) && bus.mem_rvalid_i;
  assign bus.instr_err_o   = !reset_i && (state_r == IBUSY) && timeout_s;
  assign bus.data_ack_o    = !reset_i && (state_r == DBUSY) && bus.mem_rvalid_i;
  assign bus.data_err_o    = !reset_i && (((state_r == DBUSY) && timeout_s) ||
                                          (grant_data_s && data_bad_s));
  assign bus.instr_rdata_o = bus.mem_rdata_i;
  assign bus.data_rdata_o  = bus.mem_rdata_i;
  assign bus.mem_req_o     = mem_req_r;
  assign bus.mem_addr_o    = mem_addr_r;
  assign bus.mem_wen_o     = mem_wen_r;
  assign bus.mem_wmask_o   = mem_wmask_r;
  assign bus.mem_wdata_o   = mem_wdata_r;

  // State machine, streak/timeout counters and memory-side request registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      timer_r     <= 8'd0;
      streak_r    <= 3'd0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wen_r   <= 1'b1;
      mem_wmask_r <= 4'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          timer_r <= 8'd0;
          if (!bus.instr_req_i || grant_instr_s) begin
            streak_r <= 3'd0;
          end else if (grant_data_s && (streak_r != 3'd7)) begin
            streak_r <= streak_r + 3'd1;
          end
          if (grant_instr_s) begin
            state_r     <= IBUSY;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= {bus.instr_addr_i[31:2], 2'b00};
            mem_wen_r   <= 1'b1;
            mem_wmask_r <= 4'd0;
          end else if (grant_data_s && !data_bad_s) begin
            state_r     <= DBUSY;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= {bus.data_addr_i[31:2], 2'b00};
            mem_wen_r   <= bus.data_wen_i;
            mem_wmask_r <= bus.data_wen_i ? 4'd0 : store_mask(bus.data_len_i, bus.data_addr_i[1:0]);
            mem_wdata_r <= bus.data_wdata_i << {bus.data_addr_i[1:0], 3'b000};
          end
        end
        IBUSY, DBUSY: begin
          if (bus.mem_rvalid_i || timeout_s) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            timer_r   <= 8'd0;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          timer_r   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model
// of the arbiter; every output is compared once per cycle.
module tb_mem_arbiter;
  localparam int TO   = 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TO), .DATA_STREAK_MAX(SMAX)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: who owns the port, how long it has waited, data streak
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_wait = 0;
  int          m_streak = 0;
  logic        m_req = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic        m_wen = 1'b1;
  logic [3:0]  m_mask = 4'd0;

  // requesters and memory
  logic        i_pend = 1'b0, d_pend = 1'b0;
  bit          i_again = 1'b0, d_again = 1'b0;
  logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_wen = 1'b1;
  logic [1:0]  d_len = 2'd0;
  int          mem_lat = 0;
  bit          rand_lat = 1'b0;
  bit          stale = 1'b0;
  bit          use_fix = 1'b0;
  logic [31:0] rdata_fix = 32'd0;

  // observations of the DUT for directed scenarios
  int          obs_req_cycles, obs_iack, obs_ierr, obs_dack, obs_derr;
  logic [31:0] obs_rdata, obs_addr;
  logic        prev_req = 1'b0;
  string       glog;

  task automatic clear_obs();
    obs_req_cycles = 0; obs_iack = 0; obs_ierr = 0; obs_dack = 0; obs_derr = 0;
    obs_rdata = 32'd0; obs_addr = 32'd0; glog = "";
  endtask

  function automatic bit is_misaligned(input logic [1:0] len, input logic [31:0] a);
    int size;
    if (len == 2'd3) return 1'b1;
    size = 1 << int'(len);
    return (int'(a % 32'd4) % size) != 0;
  endfunction

  task automatic pick_lat();
    int r;
    if (rand_lat) begin
      r = $urandom_range(0, 9);
      if (r <= 5) mem_lat = r % 4;
      else if (r == 6) mem_lat = TO - 1;
      else if (r == 7) mem_lat = TO - 2;
      else mem_lat = 1000;
    end
  endtask

  task automatic tick();
    int grant;
    bit e_iack, e_ierr, e_dack, e_derr, rv;
    int off, size;
    logic [31:0] rd;
    rd = use_fix ? rdata_fix : $urandom;
    rv = ((m_owner != 0) && (m_wait == mem_lat)) || ((m_owner == 0) && stale);
    bus.instr_req_i  = i_pend;
    bus.instr_addr_i = i_addr;
    bus.data_req_i   = d_pend;
    bus.data_addr_i  = d_addr;
    bus.data_wen_i   = d_wen;
    bus.data_len_i   = d_len;
    bus.data_wdata_i = d_wdata;
    bus.mem_rdata_i  = rd;
    bus.mem_rvalid_i = rv;
    #1;
    grant = 0;
    e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0;
    if (!reset) begin
      if (m_owner == 0) begin
        if (d_pend && (m_streak < SMAX || !i_pend)) grant = 2;
        else if (i_pend) grant = 1;
        if (grant == 2 && is_misaligned(d_len, d_addr)) e_derr = 1;
      end else if (rv) begin
        if (m_owner == 1) e_iack = 1; else e_dack = 1;
      end else if (m_wait + 1 == TO) begin
        if (m_owner == 1) e_ierr = 1; else e_derr = 1;
      end
    end
    check_value("instr_ack", bus.instr_ack_o, e_iack);
    check_value("instr_err", bus.instr_err_o, e_ierr);
    check_value("data_ack", bus.data_ack_o, e_dack);
    check_value("data_err", bus.data_err_o, e_derr);
    check_value("instr_rdata", bus.instr_rdata_o, rd);
    check_value("data_rdata", bus.data_rdata_o, rd);
    check_value("mem_req", bus.mem_req_o, m_req);
    check_value("mem_addr", bus.mem_addr_o, m_addr);
    check_value("mem_wen", bus.mem_wen_o, m_wen);
    check_value("mem_wmask", bus.mem_wmask_o, m_mask);
    check_value("mem_wdata", bus.mem_wdata_o, m_wdata);
    if (bus.mem_req_o === 1'b1) obs_req_cycles++;
    if (bus.mem_req_o === 1'b1 && prev_req !== 1'b1) begin
      obs_addr = bus.mem_addr_o;
      glog = {glog, (bus.mem_addr_o == 32'h2000) ? "D" : "I"};
    end
    prev_req = bus.mem_req_o;
    if (bus.instr_ack_o === 1'b1) begin obs_iack++; obs_rdata = bus.instr_rdata_o; end
    if (bus.data_ack_o === 1'b1) begin obs_dack++; obs_rdata = bus.data_rdata_o; end
    if (bus.instr_err_o === 1'b1) obs_ierr++;
    if (bus.data_err_o === 1'b1) obs_derr++;
    if (reset) begin
      m_owner = 0; m_wait = 0; m_streak = 0; m_req = 1'b0;
      m_addr = 32'd0; m_wdata = 32'd0; m_wen = 1'b1; m_mask = 4'd0;
    end else if (m_owner == 0) begin
      if (!i_pend || grant == 1) m_streak = 0;
      else if (grant == 2) m_streak = (m_streak == 7) ? 7 : m_streak + 1;
      if (grant == 1) begin
        m_owner = 1; m_req = 1'b1; m_wait = 0;
        m_addr = i_addr & ~32'd3; m_wen = 1'b1; m_mask = 4'd0;
        pick_lat();
      end else if (grant == 2 && !e_derr) begin
        off = int'(d_addr % 32'd4);
        size = 1 << int'(d_len);
        m_owner = 2; m_req = 1'b1; m_wait = 0;
        m_addr = d_addr - (d_addr % 32'd4);
        m_wen = d_wen;
        m_mask = d_wen ? 4'd0 : 4'(((1 << size) - 1) << off);
        m_wdata = d_wdata << (8 * off);
        pick_lat();
      end
    end else if (e_iack || e_ierr || e_dack || e_derr) begin
      m_owner = 0; m_req = 1'b0; m_wait = 0;
    end else begin
      m_wait++;
    end
    if (e_iack || e_ierr) i_pend = i_again;
    if (e_dack || e_derr) d_pend = d_again;
    stale = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, "_req"}, bus.mem_req_o, 1'b0);
    check_value({tag, "_wen"}, bus.mem_wen_o, 1'b1);
    check_value({tag, "_wmask"}, bus.mem_wmask_o, 4'd0);
    check_value({tag, "_addr"}, bus.mem_addr_o, 32'd0);
    check_value({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  initial begin
    string exp_order;
    logic [31:0] lw;
    clear_obs();
    bus.instr_req_i = 1'b0; bus.instr_addr_i = 32'd0; bus.data_req_i = 1'b0;
    bus.data_addr_i = 32'd0; bus.data_wen_i = 1'b1; bus.data_len_i = 2'd0;
    bus.data_wdata_i = 32'd0; bus.mem_rdata_i = 32'd0; bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b0;
    check_reset_values("reset");

    // fetch with two wait states
    clear_obs(); use_fix = 1'b1; rdata_fix = 32'hDEADBEEF; mem_lat = 2;
    i_pend = 1'b1; i_addr = 32'h1004;
    repeat (6) tick();
    check_value("fetch_addr", obs_addr, 32'h1004);
    check_value("fetch_acks", obs_iack, 1);
    check_value("fetch_rdata", obs_rdata, 32'hDEADBEEF);
    check_value("fetch_req_cycles", obs_req_cycles, 3);
    use_fix = 1'b0;

    // half-word store at offset 2
    clear_obs(); mem_lat = 0;
    d_pend = 1'b1; d_addr = 32'h2002; d_len = 2'd1; d_wen = 1'b0; d_wdata = 32'h0000ABCD;
    tick();
    check_value("st_half_wen", bus.mem_wen_o, 1'b0);
    check_value("st_half_mask", bus.mem_wmask_o, 4'b1100);
    check_value("st_half_wdata", bus.mem_wdata_o, 32'hABCD0000);
    check_value("st_half_addr", bus.mem_addr_o, 32'h2000);
    repeat (3) tick();
    check_value("st_half_acks", obs_dack, 1);

    // misaligned word store and invalid length
    clear_obs();
    d_pend = 1'b1; d_addr = 32'h2001; d_len = 2'd2; d_wen = 1'b0; d_wdata = 32'h12345678;
    tick();
    check_value("mis_word_err", obs_derr, 1);
    repeat (3) tick();
    check_value("mis_word_noreq", obs_req_cycles, 0);
    clear_obs();
    d_pend = 1'b1; d_addr = 32'h0; d_len = 2'd3; d_wen = 1'b1;
    tick();
    check_value("bad_len_err", obs_derr, 1);
    repeat (3) tick();
    check_value("bad_len_noreq", obs_req_cycles, 0);

    // both requesters saturated: starvation guard sequence
    clear_obs(); mem_lat = 0; exp_order = "DDDDIDDDDI";
    i_pend = 1'b1; i_addr = 32'h1000; i_again = 1'b1;
    d_pend = 1'b1; d_addr = 32'h2000; d_len = 2'd2; d_wen = 1'b1; d_again = 1'b1;
    for (int c = 0; c < 60 && glog.len() < 10; c++) tick();
    for (int k = 0; k < 10; k++) begin
      lw = (glog.len() > k) ? 32'(glog[k]) : 32'd0;
      check_value($sformatf("grant_order_%0d", k), lw, 32'(exp_order[k]));
    end
    i_again = 1'b0; d_again = 1'b0;
    repeat (12) tick();

    // no response: timeout, then a stale response in IDLE
    clear_obs(); mem_lat = 1000;
    d_pend = 1'b1; d_addr = 32'h3000; d_len = 2'd2; d_wen = 1'b1;
    for (int c = 0; c < 40 && obs_derr == 0; c++) tick();
    check_value("timeout_err", obs_derr, 1);
    check_value("timeout_req_cycles", obs_req_cycles, TO);
    stale = 1'b1; tick(); tick();
    check_value("stale_no_ack", obs_dack + obs_iack, 0);

    // reset in the middle of a data transaction
    clear_obs(); mem_lat = 1000;
    d_pend = 1'b1; d_addr = 32'h3004; d_len = 2'd2; d_wen = 1'b0; d_wdata = 32'hCAFEF00D;
    repeat (3) tick();
    d_pend = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    stale = 1'b1; tick(); tick();
    check_value("midrst_no_resp", obs_dack + obs_derr, 0);

    // randomized traffic
    rand_lat = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_addr = $urandom; d_wen = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) != 0) begin
          d_len = 2'($urandom_range(0, 2));
          d_addr = d_addr & ~((32'd1 << d_len) - 32'd1);
        end else begin
          d_len = 2'($urandom_range(0, 3));
        end
        d_wdata = $urandom;
        if (d_len == 2'd0) d_wdata = d_wdata & 32'h000000FF;
        else if (d_len == 2'd1) d_wdata = d_wdata & 32'h0000FFFF;
      end
      stale = ($urandom_range(0, 7) == 0);
      tick();
    end
    for (int c = 0; c < 100 && (i_pend || d_pend || m_owner != 0); c++) tick();
    check_value("drained", 32'(m_owner) + 32'(i_pend) + 32'(d_pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between instruction fetch (IF) and load/store (MEM stage). Arbitrates between the two requesters with data priority and a starvation guard. Allows one outstanding memory transaction and formats store byte-lanes from the MEM-stage length code. Detects misaligned data accesses and response timeouts, and reports both as error pulses to the requester.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for `mem_rvalid_i` before aborting a transaction; range 1..255.
- DATA_STREAK_MAX, 4: maximum number of consecutive data grants while `instr_req_i` is pending.

Ports (clock and reset first):
- clk_i  in  1  core clock; all state updates on the rising edge.
- reset_i  in  1  reset: synchronous, active-high.
- instr_req_i  in  1  fetch request; held high until ack or err.
- instr_addr_i  in  32  fetch address; word aligned, bits [1:0] ignored.
- instr_ack_o  out  1  one-cycle pulse: `instr_rdata_o` is valid.
- instr_err_o  out  1  one-cycle pulse: fetch timed out.
- instr_rdata_o  out  32  fetched word; equals `mem_rdata_i`.
- data_req_i  in  1  load/store request; held until ack or err.
- data_addr_i  in  32  byte address.
- data_wen_i  in  1  store enable, active-low (0 = store, 1 = load).
- data_len_i  in  2  0 = byte, 1 = half, 2 = word, 3 = invalid.
- data_wdata_i  in  32  store data, right-justified.
- data_ack_o  out  1  one-cycle pulse: access complete; load data valid.
- data_err_o  out  1  one-cycle pulse: misaligned access or timeout.
- data_rdata_o  out  32  raw loaded word, not shifted or extended; equals `mem_rdata_i`.
- mem_req_o  out  1  memory request, held until response or abort.
- mem_addr_o  out  32  word address; bits [1:0] are always 0.
- mem_wen_o  out  1  active-low write enable.
- mem_wmask_o  out  4  byte enables; 0 for loads.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_rdata_i  in  32  read data.
- mem_rvalid_i  in  1  response strobe for reads and writes.

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE arbitration, evaluated each cycle:
  - Data wins if `data_req_i` is high and the streak counter is below DATA_STREAK_MAX. Otherwise instruction wins if `instr_req_i` is high. Otherwise data wins if `data_req_i` is high.
  - On a data grant: if the data access is misaligned, pulse `data_err_o` in the same cycle, make no memory access, and stay in IDLE. If aligned, go to DBUSY.
  - On an instruction grant: go to IBUSY.
- Misaligned data access: `data_len_i`=1 with addr[0]=1, `data_len_i`=2 with addr[1:0]≠0, or `data_len_i`=3.
- Memory-side registers are loaded on the grant edge:
  - `mem_addr_o` = {addr[31:2], 2'b00}.
  - Loads: `mem_wen_o`=1, `mem_wmask_o`=0.
  - Stores: `mem_wen_o`=0. Byte: `mem_wmask_o` = 4'b0001<<addr[1:0]. Half: 4'b0011<<addr[1:0]. Word: 4'b1111.
  - `mem_wdata_o` = `data_wdata_i` << (8*addr[1:0]).
- IBUSY/DBUSY:
  - `mem_req_o`=1; the timeout counter increments each cycle.
  - `mem_rvalid_i`=1: pulse the owner's ack combinationally in that cycle, then go to IDLE.
  - Counter reaches TIMEOUT with no `mem_rvalid_i`: pulse the owner's err, drop `mem_req_o`, go to IDLE.
- Streak counter (3 bits, saturating):
  - Increments on each data grant made while `instr_req_i` is high.
  - Clears on any instruction grant.
  - Clears whenever `instr_req_i` is low in IDLE.
- `mem_rvalid_i` is ignored in IDLE; stale responses are dropped.

## Timing
- Reset values: state IDLE; all counters 0; `mem_req_o`=0, `mem_wen_o`=1, `mem_wmask_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0; all ack and err outputs 0.
- Request sampled high in IDLE at cycle N: `mem_req_o` rises at N+1.
- Memory with zero wait states (`mem_rvalid_i` high in the first cycle of `mem_req_o`): ack at N+1, `mem_req_o` low at N+2.
- Back-to-back: the next grant occurs in the IDLE cycle after completion. Peak throughput is one transaction per 2 cycles.
- Misaligned data error: `data_err_o` is asserted in cycle N itself. The requester must drop or change its request afterward.
- Simultaneous events:
  - `mem_rvalid_i` arrives in the same cycle the counter hits TIMEOUT: ack wins, no err.
  - Both requests high: data wins unless the streak limit is reached.
- Reset mid-transaction: IDLE on the next edge, `mem_req_o` drops, no ack or err is issued, and a later `mem_rvalid_i` is ignored.
- Requesters must hold address, length and data stable while their request is high. The arbiter registers them at grant.

## Test plan
- Instruction fetch alone, addr 0x1004, memory response after 2 wait states with rdata 0xDEADBEEF -> `mem_addr_o`=0x1004, `instr_ack_o` pulses once with rdata 0xDEADBEEF, `mem_req_o` high for exactly 3 cycles.
- Store half (`data_len_i`=1), addr 0x2002, wdata 0x0000ABCD -> `mem_wen_o`=0, `mem_wmask_o`=4'b1100, `mem_wdata_o`=0xABCD0000, `mem_addr_o`=0x2000.
- Store word at addr 0x2001 -> `data_err_o` pulses in the request cycle and `mem_req_o` never rises. Same result for `data_len_i`=3 at addr 0x0.
- Both requests held high continuously, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I.
- `mem_rvalid_i` never asserted, TIMEOUT=8 -> `data_err_o` pulses after 8 cycles of `mem_req_o`. A late `mem_rvalid_i` in IDLE produces no ack.
- Assert `reset_i` during DBUSY -> all outputs return to their reset values on the next edge, and a subsequent `mem_rvalid_i` is ignored.
